bfp_group_accumulator: RTL and testbench

//  Downstream consumer of the BFP group multiplier. Each accepted group carries per-lane sign/magnitude

---
 rtl/bfp_group_accumulator_pkg.sv | 31 +++
 rtl/bfp_group_accumulator_if.sv | 27 ++
 rtl/bfp_group_accumulator_adder_tree.sv | 25 ++
 rtl/bfp_group_accumulator.sv | 124 ++++++++++++
 tb/tb_bfp_group_accumulator.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/bfp_group_accumulator_pkg.sv
// Shared widths, lane payload type and the saturation helper for the BFP reduce/accumulate stage.
package bfp_group_accumulator_pkg;

    localparam int unsigned GRPSIZE       = 16;
    localparam int unsigned BFPEXPSIZE    = 8;
    localparam int unsigned MULBFPMANSIZE = 6;
    localparam int unsigned ACC_SIZE_DFLT = 24;

    localparam int unsigned EXPW  = BFPEXPSIZE + 1;
    localparam int unsigned LANEW = MULBFPMANSIZE + 1;
    localparam int unsigned SUMW  = LANEW + $clog2(GRPSIZE);
    localparam int unsigned SATW  = 64;

    typedef struct packed {
        logic                     sign;
        logic [MULBFPMANSIZE-1:0] man;
    } lane_t;

    // Clamp a wide signed value into the range of a w-bit two's complement number.
    function automatic logic signed [SATW-1:0] sat_acc(input logic signed [SATW-1:0] v,
                                                       input int unsigned w);
        logic signed [SATW-1:0] hi;
        logic signed [SATW-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/bfp_group_accumulator_if.sv
// Group-in / result-out handshake bundle of the BFP accumulator.
interface bfp_group_accumulator_if
    import bfp_group_accumulator_pkg::*;
#(
    parameter int unsigned ACCSIZE = ACC_SIZE_DFLT
);
    logic                             i_valid;
    logic                             o_ready;
    logic                             i_last;
    logic [GRPSIZE-1:0]               i_rslt_sign;
    logic [EXPW-1:0]                  i_rslt_exp;
    logic [GRPSIZE*MULBFPMANSIZE-1:0] i_rslt_man;
    logic                             o_valid;
    logic                             i_ready;
    logic [EXPW-1:0]                  o_acc_exp;
    logic signed [ACCSIZE-1:0]        o_acc_man;

    modport slave (
        input  i_valid, i_last, i_rslt_sign, i_rslt_exp, i_rslt_man, i_ready,
        output o_ready, o_valid, o_acc_exp, o_acc_man
    );

    modport master (
        output i_valid, i_last, i_rslt_sign, i_rslt_exp, i_rslt_man, i_ready,
        input  o_ready, o_valid, o_acc_exp, o_acc_man
    );
endinterface

// File: rtl/bfp_group_accumulator_adder_tree.sv
// Combinational signed reduction of one group of sign/magnitude lanes via a balanced binary tree.
module bfp_group_accumulator_adder_tree
    import bfp_group_accumulator_pkg::*;
(
    input  lane_t [GRPSIZE-1:0]   i_lanes,
    output logic signed [SUMW-1:0] o_sum
);
    localparam int unsigned LVLS = $clog2(GRPSIZE);

    // Level l holds GRPSIZE>>l partial sums, each one bit wider than the level below.
    for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
        logic signed [LANEW+l-1:0] v [GRPSIZE>>l];
        for (genvar k = 0; k < (GRPSIZE >> l); k++) begin : g_node
            if (l == 0) begin : g_leaf
                assign v[k] = i_lanes[k].sign ? -$signed({1'b0, i_lanes[k].man})
                                              :  $signed({1'b0, i_lanes[k].man});
            end else begin : g_sum
                assign v[k] = (LANEW + l)'(g_lvl[l-1].v[2*k]) + (LANEW + l)'(g_lvl[l-1].v[2*k+1]);
            end
        end
    end

    assign o_sum = g_lvl[LVLS].v[0];

endmodule

// File: rtl/bfp_group_accumulator.sv
// fMAC reduce/accumulate stage: sums each BFP group, aligns it to a running exponent and
// accumulates with saturation until i_last, then presents one (exp, mantissa) result.
module bfp_group_accumulator
    import bfp_group_accumulator_pkg::*;
#(
    parameter int unsigned ACCSIZE = ACC_SIZE_DFLT
)(
    input  logic                    i_clk,
    input  logic                    i_rstn,
    bfp_group_accumulator_if.slave  bus
);
    localparam int unsigned EXTW = ((ACCSIZE > SUMW) ? ACCSIZE : SUMW) + 2;

    lane_t [GRPSIZE-1:0]        w_lanes;
    logic signed [SUMW-1:0]     w_sum;
    logic                       w_en;

    logic                       r_s1_valid;
    logic signed [SUMW-1:0]     r_s1_sum;
    logic [EXPW-1:0]            r_s1_exp;
    logic                       r_s1_last;

    logic signed [ACCSIZE-1:0]  r_acc_man;
    logic [EXPW-1:0]            r_acc_exp;
    logic                       r_acc_nz;

    logic                       r_o_valid;
    logic signed [ACCSIZE-1:0]  r_o_acc_man;
    logic [EXPW-1:0]            r_o_acc_exp;

    logic                       w_exp_gt;
    logic [EXPW-1:0]            w_d;
    logic signed [EXTW-1:0]     w_acc_ext;
    logic signed [EXTW-1:0]     w_sum_ext;
    logic signed [EXTW-1:0]     w_add;
    logic signed [ACCSIZE-1:0]  w_sat;
    logic signed [ACCSIZE-1:0]  w_upd_man;
    logic [EXPW-1:0]            w_upd_exp;
    logic                       w_upd_nz;

    for (genvar k = 0; k < GRPSIZE; k++) begin : g_lane
        assign w_lanes[k].sign = bus.i_rslt_sign[k];
        assign w_lanes[k].man  = bus.i_rslt_man[k*MULBFPMANSIZE +: MULBFPMANSIZE];
    end

    bfp_group_accumulator_adder_tree u_tree (
        .i_lanes (w_lanes),
        .o_sum   (w_sum)
    );

    // Whole pipeline freezes only when a finished result is waiting on the consumer.
    assign w_en = ~(r_o_valid & ~bus.i_ready);

    // Align the smaller-exponent operand, add wide, then saturate to the accumulator width.
    always_comb begin
        w_exp_gt  = r_s1_exp > r_acc_exp;
        w_d       = w_exp_gt ? (r_s1_exp - r_acc_exp) : (r_acc_exp - r_s1_exp);
        w_acc_ext = EXTW'(r_acc_man);
        w_sum_ext = EXTW'(r_s1_sum);
        w_add     = w_exp_gt ? ((w_acc_ext >>> w_d) + w_sum_ext)
                             : (w_acc_ext + (w_sum_ext >>> w_d));
        w_sat     = ACCSIZE'(sat_acc(SATW'(w_add), ACCSIZE));

        w_upd_man = r_acc_man;
        w_upd_exp = r_acc_exp;
        w_upd_nz  = r_acc_nz;
        if (r_s1_sum != '0) begin
            w_upd_nz = 1'b1;
            if (!r_acc_nz) begin
                w_upd_man = ACCSIZE'(sat_acc(SATW'(r_s1_sum), ACCSIZE));
                w_upd_exp = r_s1_exp;
            end else begin
                w_upd_man = w_sat;
                if (w_exp_gt) w_upd_exp = r_s1_exp;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_s1_valid  <= 1'b0;
            r_s1_sum    <= '0;
            r_s1_exp    <= '0;
            r_s1_last   <= 1'b0;
            r_acc_man   <= '0;
            r_acc_exp   <= '0;
            r_acc_nz    <= 1'b0;
            r_o_valid   <= 1'b0;
            r_o_acc_man <= '0;
            r_o_acc_exp <= '0;
        end else if (w_en) begin
            r_s1_valid <= bus.i_valid;
            r_s1_sum   <= w_sum;
            r_s1_exp   <= bus.i_rslt_exp;
            r_s1_last  <= bus.i_last;

            if (r_s1_valid) begin
                if (r_s1_last) begin
                    r_acc_man <= '0;
                    r_acc_exp <= '0;
                    r_acc_nz  <= 1'b0;
                end else begin
                    r_acc_man <= w_upd_man;
                    r_acc_exp <= w_upd_exp;
                    r_acc_nz  <= w_upd_nz;
                end
            end

            if (r_s1_valid && r_s1_last) begin
                r_o_valid   <= 1'b1;
                r_o_acc_man <= w_upd_man;
                r_o_acc_exp <= w_upd_exp;
            end else if (bus.i_ready) begin
                r_o_valid <= 1'b0;
            end
        end
    end

    assign bus.o_ready   = w_en;
    assign bus.o_valid   = r_o_valid;
    assign bus.o_acc_man = r_o_acc_man;
    assign bus.o_acc_exp = r_o_acc_exp;

endmodule

// File: tb/tb_bfp_group_accumulator.sv
// Directed bench for bfp_group_accumulator: default instance plus a narrow-accumulator instance for saturation.
module tb_bfp_group_accumulator;
    import bfp_group_accumulator_pkg::*;

    localparam int unsigned MANV = GRPSIZE * MULBFPMANSIZE;

    logic clk = 1'b0;
    logic rstn;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    bfp_group_accumulator_if #(.ACCSIZE(24)) bus ();
    bfp_group_accumulator_if #(.ACCSIZE(10)) bus_s ();

    bfp_group_accumulator #(.ACCSIZE(24)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    bfp_group_accumulator #(.ACCSIZE(10)) dut_s (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus_s)
    );

    function automatic logic [MANV-1:0] rep(input logic [MULBFPMANSIZE-1:0] v);
        return {GRPSIZE{v}};
    endfunction

    // Present one group for a single clock edge, then drop i_valid.
    task automatic drive_grp(input logic [GRPSIZE-1:0] sgn, input logic [MANV-1:0] man,
                             input logic [EXPW-1:0] exp, input logic last);
        bus.i_valid     = 1'b1;
        bus.i_rslt_sign = sgn;
        bus.i_rslt_man  = man;
        bus.i_rslt_exp  = exp;
        bus.i_last      = last;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
    endtask

    task automatic drive_small(input logic [MANV-1:0] man, input logic [EXPW-1:0] exp,
                               input logic last);
        bus_s.i_valid     = 1'b1;
        bus_s.i_rslt_sign = '0;
        bus_s.i_rslt_man  = man;
        bus_s.i_rslt_exp  = exp;
        bus_s.i_last      = last;
        @(posedge clk); #1;
        bus_s.i_valid = 1'b0;
        bus_s.i_last  = 1'b0;
    endtask

    task automatic wait_out();
        for (int i = 0; i < 20; i++) begin
            if (bus.o_valid === 1'b1) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid got %0b want 0", bus.o_valid); end
        n_checks++; if (bus.o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_o_ready got %0b want 1", bus.o_ready); end
        n_checks++; if (bus.o_acc_man !== 24'sd0) begin n_fail++; $display("FAIL reset_man got %0d want 0", bus.o_acc_man); end
        n_checks++; if (bus.o_acc_exp !== 9'd0) begin n_fail++; $display("FAIL reset_exp got %0d want 0", bus.o_acc_exp); end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        drive_grp('0, rep(6'd3), 9'd10, 1'b1);
        n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL single_early got %0b want 0", bus.o_valid); end
        @(posedge clk); #1;
        n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0b want 1", bus.o_valid); end
        n_checks++; if (bus.o_acc_man !== 24'sd48) begin n_fail++; $display("FAIL single_man got %0d want 48", bus.o_acc_man); end
        n_checks++; if (bus.o_acc_exp !== 9'd10) begin n_fail++; $display("FAIL single_exp got %0d want 10", bus.o_acc_exp); end
        @(posedge clk); #1;
        n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL single_taken got %0b want 0", bus.o_valid); end
    endtask

    task automatic test_align();
        logic [MANV-1:0] m;
        m = '0;
        m[MULBFPMANSIZE-1:0] = 6'd16;
        drive_grp('0, rep(6'd3), 9'd10, 1'b0);
        drive_grp('0, m, 9'd12, 1'b1);
        wait_out();
        n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL align_valid got %0b want 1", bus.o_valid); end
        n_checks++; if (bus.o_acc_man !== 24'sd28) begin n_fail++; $display("FAIL align_man got %0d want 28", bus.o_acc_man); end
        n_checks++; if (bus.o_acc_exp !== 9'd12) begin n_fail++; $display("FAIL align_exp got %0d want 12", bus.o_acc_exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_group();
        drive_grp(16'h00FF, rep(6'd5), 9'd20, 1'b0);
        drive_grp('0, rep(6'd3), 9'd10, 1'b1);
        wait_out();
        n_checks++; if (bus.o_acc_man !== 24'sd48) begin n_fail++; $display("FAIL zero_grp_man got %0d want 48", bus.o_acc_man); end
        n_checks++; if (bus.o_acc_exp !== 9'd10) begin n_fail++; $display("FAIL zero_grp_exp got %0d want 10", bus.o_acc_exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_saturate();
        for (int g = 0; g < 11; g++) drive_small(rep(6'd3), 9'd4, (g == 10));
        for (int i = 0; i < 20; i++) begin
            if (bus_s.o_valid === 1'b1) break;
            @(posedge clk); #1;
        end
        n_checks++; if (bus_s.o_valid !== 1'b1) begin n_fail++; $display("FAIL sat_valid got %0b want 1", bus_s.o_valid); end
        n_checks++; if (bus_s.o_acc_man !== 10'sd511) begin n_fail++; $display("FAIL sat_man got %0d want 511", bus_s.o_acc_man); end
        n_checks++; if (bus_s.o_acc_exp !== 9'd4) begin n_fail++; $display("FAIL sat_exp got %0d want 4", bus_s.o_acc_exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        bus.i_ready = 1'b0;
        drive_grp('0, rep(6'd3), 9'd10, 1'b1);
        wait_out();
        // Offer a group during the stall; it must not be taken.
        bus.i_valid     = 1'b1;
        bus.i_last      = 1'b1;
        bus.i_rslt_sign = '0;
        bus.i_rslt_man  = rep(6'd1);
        bus.i_rslt_exp  = 9'd7;
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (bus.o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready c%0d got %0b want 0", c, bus.o_ready); end
            n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid c%0d got %0b want 1", c, bus.o_valid); end
            n_checks++; if (bus.o_acc_man !== 24'sd48) begin n_fail++; $display("FAIL bp_man c%0d got %0d want 48", c, bus.o_acc_man); end
            n_checks++; if (bus.o_acc_exp !== 9'd10) begin n_fail++; $display("FAIL bp_exp c%0d got %0d want 10", c, bus.o_acc_exp); end
            @(posedge clk); #1;
        end
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_handshake got %0b want 0", bus.o_valid); end
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_phantom got %0b want 0", bus.o_valid); end
        drive_grp('0, rep(6'd1), 9'd7, 1'b1);
        wait_out();
        n_checks++; if (bus.o_acc_man !== 24'sd16) begin n_fail++; $display("FAIL bp_next_man got %0d want 16", bus.o_acc_man); end
        n_checks++; if (bus.o_acc_exp !== 9'd7) begin n_fail++; $display("FAIL bp_next_exp got %0d want 7", bus.o_acc_exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midseq();
        drive_grp('0, rep(6'd3), 9'd10, 1'b0);
        drive_grp('0, rep(6'd3), 9'd10, 1'b0);
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %0b want 0", bus.o_valid); end
        n_checks++; if (bus.o_acc_man !== 24'sd0) begin n_fail++; $display("FAIL midrst_man got %0d want 0", bus.o_acc_man); end
        n_checks++; if (bus.o_acc_exp !== 9'd0) begin n_fail++; $display("FAIL midrst_exp got %0d want 0", bus.o_acc_exp); end
        drive_grp('0, rep(6'd3), 9'd5, 1'b1);
        wait_out();
        n_checks++; if (bus.o_acc_man !== 24'sd48) begin n_fail++; $display("FAIL midrst_next_man got %0d want 48", bus.o_acc_man); end
        n_checks++; if (bus.o_acc_exp !== 9'd5) begin n_fail++; $display("FAIL midrst_next_exp got %0d want 5", bus.o_acc_exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_big_shift();
        drive_grp('0, rep(6'd3), 9'd30, 1'b0);
        drive_grp(16'hFFFF, rep(6'd3), 9'd0, 1'b1);
        wait_out();
        n_checks++; if (bus.o_acc_man !== 24'sd47) begin n_fail++; $display("FAIL bigshift_man got %0d want 47", bus.o_acc_man); end
        n_checks++; if (bus.o_acc_exp !== 9'd30) begin n_fail++; $display("FAIL bigshift_exp got %0d want 30", bus.o_acc_exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        drive_grp('0, rep(6'd1), 9'd3, 1'b1);
        drive_grp(16'hFFFF, rep(6'd2), 9'd4, 1'b1);
        n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first_valid got %0b want 1", bus.o_valid); end
        n_checks++; if (bus.o_acc_man !== 24'sd16) begin n_fail++; $display("FAIL b2b_first_man got %0d want 16", bus.o_acc_man); end
        n_checks++; if (bus.o_acc_exp !== 9'd3) begin n_fail++; $display("FAIL b2b_first_exp got %0d want 3", bus.o_acc_exp); end
        @(posedge clk); #1;
        n_checks++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid got %0b want 1", bus.o_valid); end
        n_checks++; if (bus.o_acc_man !== -24'sd32) begin n_fail++; $display("FAIL b2b_second_man got %0d want -32", bus.o_acc_man); end
        n_checks++; if (bus.o_acc_exp !== 9'd4) begin n_fail++; $display("FAIL b2b_second_exp got %0d want 4", bus.o_acc_exp); end
        @(posedge clk); #1;
        n_checks++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %0b want 0", bus.o_valid); end
    endtask

    initial begin
        bus.i_valid       = 1'b0;
        bus.i_last        = 1'b0;
        bus.i_rslt_sign   = '0;
        bus.i_rslt_exp    = '0;
        bus.i_rslt_man    = '0;
        bus.i_ready       = 1'b1;
        bus_s.i_valid     = 1'b0;
        bus_s.i_last      = 1'b0;
        bus_s.i_rslt_sign = '0;
        bus_s.i_rslt_exp  = '0;
        bus_s.i_rslt_man  = '0;
        bus_s.i_ready     = 1'b1;
        rstn              = 1'b0;

        test_reset();
        test_single();
        test_align();
        test_zero_group();
        test_saturate();
        test_backpressure();
        test_reset_midseq();
        test_big_shift();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
